// File: rtl/dmu_pkg.sv
// Shared definitions for the data-memory-unit arbiter: FSM encoding, port
// indices and default geometry.
package dmu_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned DEPTH_DEFAULT = 128;

  // One-hot request/grant bit for a port index.
  function automatic logic [1:0] port_bit(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: masked requests in, winner index
// and "anything eligible" out.
module rr_arb2
  import dmu_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       rr_last_i,
  output logic       win_o,
  output logic       any_o
);

  logic [1:0] elig;

  assign elig  = req_i & ~mask_i;
  assign any_o = |elig;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    win_o = P0;
    if (elig == 2'b11) begin
      win_o = ~rr_last_i;
    end else if (elig[1]) begin
      win_o = P1;
    end
  end

endmodule

// File: rtl/dmu_arbiter.sv
// Round-robin arbiter and sequencer sharing a single-port data memory between
// the core load/store port (P0) and the debug/DMA port (P1).
module dmu_arbiter
  import dmu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [WIDTH-1:0] p0_rdata,
  output logic             p0_err,

  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             p1_err,

  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             rr_last_q, rr_last_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0]       req_vec;
  logic [1:0]       mask_vec;
  logic [1:0]       we_vec;
  logic [WIDTH-1:0] addr_vec  [2];
  logic [WIDTH-1:0] wdata_vec [2];
  logic             win;
  logic             any_req;
  logic             in_access;
  logic             access_ok;
  logic [1:0]       gnt_vec;
  logic [1:0]       rvalid_vec;
  logic [1:0]       rerr_vec;
  logic [WIDTH-1:0] rdata_vec [2];
  logic [WIDTH-1:0] resp_data;

  // Memory is one-based: word 0 and anything past DEPTH are rejected.
  function automatic logic out_of_range(input logic [WIDTH-1:0] a);
    return (a == '0) || (a > WIDTH'(DEPTH));
  endfunction

  assign req_vec      = {p1_req, p0_req};
  assign we_vec       = {p1_we, p0_we};
  assign addr_vec[0]  = p0_addr;
  assign addr_vec[1]  = p1_addr;
  assign wdata_vec[0] = p0_wdata;
  assign wdata_vec[1] = p1_wdata;

  assign in_access = (state_q == ST_ACCESS);
  // The current owner's request is being consumed this cycle, so hide it.
  assign mask_vec  = in_access ? port_bit(owner_q) : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req_i     (req_vec),
    .mask_i    (mask_vec),
    .rr_last_i (rr_last_q),
    .win_o     (win),
    .any_o     (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= P0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rr_last_q <= P1;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      err_q     <= err_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    err_d     = err_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: if (!any_req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (any_req) begin
      owner_d   = win;
      we_d      = we_vec[win];
      addr_d    = addr_vec[win];
      wdata_d   = wdata_vec[win];
      err_d     = out_of_range(addr_vec[win]);
      rr_last_d = win;
    end
  end

  // Reset in the middle of an access must leave no memory side effect.
  assign access_ok = in_access && !err_q && !rst;

  always_comb begin
    gnt_vec      = 2'b00;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (in_access && !rst) begin
      gnt_vec = port_bit(owner_q);
    end
    if (access_ok) begin
      mem_write_en = we_q;
      mem_read_en  = !we_q;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
    end
  end

  assign resp_data = (err_q || we_q) ? '0 : mem_rdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic             hit;
    logic             rvalid_q;
    logic             rerr_q;
    logic [WIDTH-1:0] rdata_q;

    assign hit = in_access && (owner_q == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        rerr_q   <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= hit;
        if (hit) begin
          rerr_q  <= err_q;
          rdata_q <= resp_data;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_q;
    assign rerr_vec[gi]   = rerr_q;
    assign rdata_vec[gi]  = rdata_q;
  end

  assign p0_gnt    = gnt_vec[0];
  assign p0_rvalid = rvalid_vec[0];
  assign p0_err    = rerr_vec[0];
  assign p0_rdata  = rdata_vec[0];
  assign p1_gnt    = gnt_vec[1];
  assign p1_rvalid = rvalid_vec[1];
  assign p1_err    = rerr_vec[1];
  assign p1_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_dmu_arbiter.sv
// Scoreboard bench for dmu_arbiter: drivers push expected responses, a forked
// monitor pops and compares them; a small memory model sits on the mem pins.
`timescale 1ns/1ps
module tb_dmu_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_s = '0;
  logic [1:0]       we_s = '0;
  logic [WIDTH-1:0] addr_s [2];
  logic [WIDTH-1:0] wdata_s [2];
  logic [1:0]       gnt_s, rvalid_s, err_s;
  logic [WIDTH-1:0] rdata_s [2];
  logic             mem_read_en, mem_write_en;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

  logic [WIDTH-1:0] mem [0:DEPTH];
  logic [WIDTH-1:0] model_mem [0:DEPTH];
  exp_t exp0 [$];
  exp_t exp1 [$];
  int   gnt_log [$];
  int   gnt_cyc [$];
  int   last_gnt [2];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  dmu_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_req(req_s[0]), .p0_we(we_s[0]), .p0_addr(addr_s[0]), .p0_wdata(wdata_s[0]),
    .p0_gnt(gnt_s[0]), .p0_rvalid(rvalid_s[0]), .p0_rdata(rdata_s[0]), .p0_err(err_s[0]),
    .p1_req(req_s[1]), .p1_we(we_s[1]), .p1_addr(addr_s[1]), .p1_wdata(wdata_s[1]),
    .p1_gnt(gnt_s[1]), .p1_rvalid(rvalid_s[1]), .p1_rdata(rdata_s[1]), .p1_err(err_s[1]),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed_val(input int i);
    return 32'(i) * 32'h0100_0193 + 32'hA5A5_0000;
  endfunction

  function automatic logic oor(input logic [31:0] a);
    return (a == 32'd0) || (a > 32'(DEPTH));
  endfunction

  // One-based memory with combinational read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i <= DEPTH; i++) mem[i] <= seed_val(i);
    end else if (mem_write_en && !oor(mem_addr)) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (!oor(mem_addr)) mem_rdata = mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (gnt_s == 2'b11) chk("gnt_onehot", 32'(gnt_s), 32'd1);
        for (int p = 0; p < 2; p++) begin
          if (gnt_s[p]) begin
            logic bad;
            bad = oor(addr_s[p]);
            gnt_log.push_back(p);
            gnt_cyc.push_back(cyc);
            last_gnt[p] = cyc;
            chk("mem_wen", 32'(mem_write_en), 32'(!bad && we_s[p]));
            chk("mem_ren", 32'(mem_read_en), 32'(!bad && !we_s[p]));
            chk("mem_addr", mem_addr, bad ? 32'd0 : addr_s[p]);
            chk("mem_wdata", mem_wdata, bad ? 32'd0 : wdata_s[p]);
          end
          if (rvalid_s[p]) begin
            exp_t e;
            chk("rvalid_latency", 32'(cyc), 32'(last_gnt[p] + 1));
            if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
              chk("rvalid_unexpected", 32'(p), 32'hFFFF_FFFF);
            end else begin
              e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
              $display("txn p%0d rdata=%h err=%0d cycle=%0d", p, rdata_s[p], err_s[p], cyc);
              chk("rdata", rdata_s[p], e.rdata);
              chk("err", 32'(err_s[p]), 32'(e.err));
            end
          end
        end
        if (gnt_s == 2'b00) begin
          chk("mem_idle_en", 32'({mem_read_en, mem_write_en}), 32'd0);
          chk("mem_idle_bus", mem_addr | mem_wdata, 32'd0);
        end
      end
    end
  endtask

  // Issue one access starting at posedge+1; returns at posedge+1 after the grant.
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int waited);
    exp_t e;
    logic got;
    e.err   = oor(a);
    e.rdata = (e.err || w) ? 32'd0 : model_mem[a[7:0]];
    if (!e.err && w) model_mem[a[7:0]] = d;
    if (p == 0) exp0.push_back(e); else exp1.push_back(e);
    we_s[p] = w; addr_s[p] = a; wdata_s[p] = d; req_s[p] = 1'b1;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      got = gnt_s[p];
    end
    if (!got) chk("gnt_timeout", 32'(p), 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    req_s[p] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int p);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32'd0;
    if (r == 1) return 32'(DEPTH + 1);
    if (r == 2) return $urandom | 32'h8000_0000;
    return 32'((p == 0) ? 1 : 65) + 32'($urandom_range(0, 63));
  endfunction

  initial begin
    int w0, w1, mism;
    logic [31:0] r0, r1;
    addr_s[0] = '0; addr_s[1] = '0; wdata_s[0] = '0; wdata_s[1] = '0;
    last_gnt[0] = -10; last_gnt[1] = -10;
    for (int i = 0; i <= DEPTH; i++) model_mem[i] = seed_val(i);
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_s), 32'd0);
    chk("rst_rvalid", 32'(rvalid_s), 32'd0);
    chk("rst_err", 32'(err_s), 32'd0);
    chk("rst_rdata0", rdata_s[0], 32'd0);
    chk("rst_rdata1", rdata_s[1], 32'd0);
    chk("rst_mem_en", 32'({mem_read_en, mem_write_en}), 32'd0);
    @(posedge clk); #1;
    preload = 1'b0; rst = 1'b0;

    // Ties straight after reset: P0 first, P1 back-to-back, next tie P0 again
    for (int t = 0; t < 2; t++) begin
      gnt_log.delete(); gnt_cyc.delete();
      fork
        issue(0, 1'b0, 32'd10 + 32'(t), 32'd0, w0);
        issue(1, 1'b0, 32'd70 + 32'(t), 32'd0, w1);
      join
      if (gnt_log.size() != 2) chk("tie_count", 32'(gnt_log.size()), 32'd2);
      else begin
        chk("tie_first", 32'(gnt_log[0]), 32'd0);
        chk("tie_second", 32'(gnt_log[1]), 32'd1);
        chk("tie_b2b", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd1);
      end
    end

    // Write then read back on P0, with latency and single-port throughput
    gnt_log.delete(); gnt_cyc.delete();
    issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, w0);
    chk("t1_gnt_latency", 32'(w0), 32'd2);
    issue(0, 1'b0, 32'd5, 32'd0, w0);
    if (gnt_cyc.size() == 2) chk("t1_single_rate", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd2);
    else chk("t1_gnt_count", 32'(gnt_cyc.size()), 32'd2);

    // Continuous requests on both ports alternate with no idle cycles
    gnt_log.delete(); gnt_cyc.delete();
    fork
      begin
        int w;
        for (int i = 0; i < 4; i++) issue(0, 1'($urandom), rand_addr(0) | 32'd1 & 32'd63 | 32'd1, $urandom, w);
      end
      begin
        int w;
        for (int i = 0; i < 4; i++) issue(1, 1'($urandom), 32'd65 + 32'($urandom_range(0, 63)), $urandom, w);
      end
    join
    if (gnt_log.size() != 8) chk("alt_count", 32'(gnt_log.size()), 32'd8);
    else begin
      for (int i = 1; i < 8; i++) begin
        chk("alt_port", 32'(gnt_log[i]), 32'(1 - gnt_log[i-1]));
        chk("alt_b2b", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd1);
      end
    end

    // Out-of-range accesses on P1
    issue(1, 1'b0, 32'd0, 32'd0, w1);
    issue(1, 1'b1, 32'(DEPTH + 1), 32'h1234_5678, w1);

    // Reset during the access cycle of a P0 write
    issue(0, 1'b1, 32'd7, 32'h1111_1111, w0);
    we_s[0] = 1'b1; addr_s[0] = 32'd7; wdata_s[0] = 32'hBAD0_BAD0; req_s[0] = 1'b1;
    w0 = 0;
    while (!gnt_s[0] && w0 < 20) begin @(negedge clk); w0++; end
    chk("t5_gnt_seen", 32'(gnt_s[0]), 32'd1);
    #1 rst = 1'b1;
    #1 chk("t5_wen_gated", 32'(mem_write_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rvalid", 32'(rvalid_s[0]), 32'd0);
    end
    @(posedge clk); #1;
    issue(0, 1'b0, 32'd7, 32'd0, w0);
    issue(1, 1'b0, 32'd100, 32'd0, w1);

    // Idle bus: nothing moves and read data holds
    @(posedge clk); #1;
    r0 = rdata_s[0]; r1 = rdata_s[1];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctl", 32'({gnt_s, rvalid_s, mem_read_en, mem_write_en}), 32'd0);
      chk("idle_hold", rdata_s[0] ^ r0 | rdata_s[1] ^ r1, 32'd0);
    end
    @(posedge clk); #1;

    // Randomised traffic, disjoint address halves per port
    fork
      begin
        int w;
        for (int i = 0; i < 40; i++) begin
          int gap;
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
          issue(0, 1'($urandom), rand_addr(0), $urandom, w);
        end
      end
      begin
        int w;
        for (int i = 0; i < 40; i++) begin
          int gap;
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
          issue(1, 1'($urandom), rand_addr(1), $urandom, w);
        end
      end
    join

    for (int i = 0; i < 10 && (exp0.size() + exp1.size()) != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_p0", 32'(exp0.size()), 32'd0);
    chk("drain_p1", 32'(exp1.size()), 32'd0);
    mism = 0;
    for (int i = 1; i <= DEPTH; i++) if (mem[i] !== model_mem[i]) mism++;
    chk("mem_contents", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
